// File: rtl/pkt_uart_tx_pkg.sv
// Shared constants and FSM encoding for the LiDAR packet UART transmitter.
package pkt_uart_tx_pkg;

  localparam logic [15:0] PKT_HEADER = 16'h542C;
  localparam int          PKT_BYTES  = 23;
  localparam int          PKT_BITS   = 184;
  localparam int          BAUD_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_uart_tx_baud.sv
// Bit-period counter: bit_end pulses on the last cycle of every UART bit.
module baud_tick_gen
  import pkt_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST) && !clear;

endmodule

// File: rtl/pkt_uart_tx.sv
// Captures a 184-bit LiDAR packet on a synchronized pkt_valid edge and
// streams it MSB byte first as 8N1 UART frames.
module pkt_uart_tx
  import pkt_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pkt_valid,
  input  logic [183:0] pkt_data,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         hdr_err,
  output logic [7:0]   drop_cnt
);

  localparam logic [4:0] LAST_BYTE = 5'(PKT_BYTES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                state, state_nxt;
  logic                  sync_p0, sync_p1, sync_d;
  logic [1:0]            fill;
  logic                  armed;
  logic                  pkt_evt, idle_free, hdr_ok, accept, last_stop, bit_end;
  logic [2:0]            bit_idx;
  logic [4:0]            byte_idx;
  logic [PKT_BITS-1:0]   buffer;
  logic [7:0]            cur_byte;

  // Synchronizer and edge detect; armed blocks events until a low level has
  // been seen after reset, so a pkt_valid held high across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_d  <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync_p0 <= pkt_valid;
      sync_p1 <= sync_p0;
      sync_d  <= sync_p1;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & ~sync_p1);
    end
  end

  assign pkt_evt   = sync_p1 & ~sync_d & armed;
  assign idle_free = (state == ST_IDLE) && !done;
  assign hdr_ok    = (pkt_data[PKT_BITS-1 -: 16] == PKT_HEADER);
  assign accept    = pkt_evt && idle_free && hdr_ok;
  assign last_stop = (state == ST_STOP) && bit_end && (byte_idx == LAST_BYTE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (bit_end) state_nxt = (byte_idx < LAST_BYTE) ? ST_START : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign cur_byte = buffer[PKT_BITS-1 -: 8];

  always_comb begin
    tx   = 1'b1;
    busy = (state != ST_IDLE);
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = cur_byte[bit_idx];
      default:  tx = 1'b1;
    endcase
  end

  // Buffer shifts one byte left after each stop bit so the next byte is on top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer   <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      done     <= 1'b0;
      hdr_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done    <= last_stop;
      hdr_err <= pkt_evt && idle_free && !hdr_ok;
      if (pkt_evt && !idle_free)
        drop_cnt <= sat_inc8(drop_cnt);
      if (accept) begin
        buffer   <= pkt_data;
        bit_idx  <= '0;
        byte_idx <= '0;
      end else if (bit_end) begin
        case (state)
          ST_DATA: bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
          ST_STOP: begin
            buffer   <= {buffer[PKT_BITS-9:0], 8'h00};
            byte_idx <= (byte_idx == LAST_BYTE) ? 5'd0 : byte_idx + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_uart_tx.sv
// Scoreboard bench for pkt_uart_tx at CLKS_PER_BIT=4: expected bytes queued at
// capture, decoded UART bytes queued by a line monitor, compared per scenario.
module tb_pkt_uart_tx;

  localparam int CPB = 4;

  logic         clk, reset, pkt_valid;
  logic [183:0] pkt_data;
  logic         tx, busy, done, hdr_err;
  logic [7:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];
  logic [7:0] mon_b;
  logic       mon_ok;
  logic [8:0] rxb;
  logic [7:0] exb;

  pkt_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .pkt_data (pkt_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .hdr_err  (hdr_err),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART line monitor: samples each bit mid-period, records {stop_ok, byte}.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        mon_ok = 1'b1;
        repeat (CPB/2) @(negedge clk);
        if (reset || !busy || tx !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
          if (reset || !busy) mon_ok = 1'b0;
        end
        repeat (CPB) @(negedge clk);
        if (reset || !busy) mon_ok = 1'b0;
        if (mon_ok) rx_q.push_back({tx === 1'b1, mon_b});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [183:0] mk_pkt(input logic [15:0] hdr);
    logic [183:0] d;
    d[183:168] = hdr;
    for (int i = 0; i < 21; i++) d[167-8*i -: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic push_exp(input logic [183:0] d);
    for (int i = 0; i < 23; i++) exp_q.push_back(d[183-8*i -: 8]);
  endtask

  // Raises pkt_valid and returns at the first sample where tx is low.
  task automatic start_frame(input logic [183:0] d, output bit found);
    found = 1'b0;
    pkt_data = d;
    @(negedge clk);
    pkt_valid = 1'b1;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || hdr_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b hdr_err=%b want 0 0", done, hdr_err); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [183:0] d;
    int cyc;
    d[183:168] = 16'h542C;
    for (int i = 0; i < 21; i++) d[167-8*i -: 8] = 8'(i + 1);
    pkt_data = d;
    push_exp(d);
    @(negedge clk);
    pkt_valid = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL nom_edge%0d: tx=%b busy=%b want 1 0", e, tx, busy); end
    end
    @(negedge clk);
    n_checks++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nom_edge3: tx=%b busy=%b want 0 1", tx, busy); end
    pkt_valid = 1'b0;
    cyc = 1;
    while (cyc <= 2000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cyc++;
    end
    n_checks++; if (cyc != 920) begin n_fail++; $display("FAIL nom_busy_len: got %0d want 920", cyc); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nom_done_hi: got %b want 1", done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nom_done_lo: got %b want 0", done); end
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL nom_byte%0d: got none want %h", i, exp_q[0]); end
      else begin
        rxb = rx_q.pop_front(); exb = exp_q.pop_front();
        if (rxb !== {1'b1, exb}) begin n_fail++; $display("FAIL nom_byte%0d: got %h want %h", i, rxb, {1'b1, exb}); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_bad_header();
    pkt_data = mk_pkt(16'hFFFF);
    @(negedge clk);
    pkt_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("FAIL badhdr_early: got %b want 0", hdr_err); end
    @(negedge clk);
    n_checks++; if (hdr_err !== 1'b1) begin n_fail++; $display("FAIL badhdr_pulse: got %b want 1", hdr_err); end
    pkt_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("FAIL badhdr_end: got %b want 0", hdr_err); end
    repeat (20) @(negedge clk);
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL badhdr_idle: tx=%b busy=%b want 1 0", tx, busy); end
  endtask

  task automatic test_overrun();
    logic [183:0] d;
    bit found;
    d = mk_pkt(16'h542C);
    push_exp(d);
    start_frame(d, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL ovr_start: got no start bit want start"); end
    repeat (399) @(negedge clk);
    pkt_data = mk_pkt(16'h542C);
    pkt_valid = 1'b1;
    repeat (3) @(negedge clk);
    pkt_valid = 1'b0;
    for (int c = 0; c < 2000 && busy === 1'b1; c++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_timeout: busy=%b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_drop: got %0d want 1", drop_cnt); end
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL ovr_byte%0d: got none want %h", i, exp_q[0]); end
      else begin
        rxb = rx_q.pop_front(); exb = exp_q.pop_front();
        if (rxb !== {1'b1, exb}) begin n_fail++; $display("FAIL ovr_byte%0d: got %h want %h", i, rxb, {1'b1, exb}); end
      end
    end
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_done_coincident();
    logic [183:0] d;
    bit found;
    bit restarted;
    d = mk_pkt(16'h542C);
    push_exp(d);
    start_frame(d, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL coin_start: got no start bit want start"); end
    repeat (918) @(negedge clk);
    pkt_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coin_busy_pre: got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL coin_done: done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk);
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL coin_drop: got %0d want 2", drop_cnt); end
    restarted = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) restarted = 1'b1;
    end
    n_checks++; if (restarted) begin n_fail++; $display("FAIL coin_nostart: got restart=1 want 0"); end
    pkt_valid = 1'b0;
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL coin_byte%0d: got none want %h", i, exp_q[0]); end
      else begin
        rxb = rx_q.pop_front(); exb = exp_q.pop_front();
        if (rxb !== {1'b1, exb}) begin n_fail++; $display("FAIL coin_byte%0d: got %h want %h", i, rxb, {1'b1, exb}); end
      end
    end
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [183:0] d;
    bit found;
    d = mk_pkt(16'h542C);
    push_exp(d);
    start_frame(d, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL sat_start: got no start bit want start"); end
    for (int k = 0; k < 300; k++) begin
      pkt_valid = 1'b0;
      @(negedge clk);
      pkt_valid = 1'b1;
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    for (int c = 0; c < 2000 && busy === 1'b1; c++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_timeout: busy=%b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL sat_byte%0d: got none want %h", i, exp_q[0]); end
      else begin
        rxb = rx_q.pop_front(); exb = exp_q.pop_front();
        if (rxb !== {1'b1, exb}) begin n_fail++; $display("FAIL sat_byte%0d: got %h want %h", i, rxb, {1'b1, exb}); end
      end
    end
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [183:0] d;
    bit found;
    bit started;
    d = mk_pkt(16'h542C);
    start_frame(d, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_start: got no start bit want start"); end
    repeat (500) @(negedge clk);
    #2;
    reset = 1'b1;
    pkt_valid = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: tx=%b busy=%b want 1 0", tx, busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    started = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) started = 1'b1;
    end
    n_checks++; if (started) begin n_fail++; $display("FAIL rst_held_valid: got start=1 want 0"); end
    pkt_valid = 1'b0;
    rx_q.delete();
    exp_q.delete();
    repeat (5) @(negedge clk);
    d = mk_pkt(16'h542C);
    push_exp(d);
    start_frame(d, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_fresh_start: got no start bit want start"); end
    for (int c = 0; c < 2000 && busy === 1'b1; c++) @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      n_checks++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL rst_byte%0d: got none want %h", i, exp_q[0]); end
      else begin
        rxb = rx_q.pop_front(); exb = exp_q.pop_front();
        if (rxb !== {1'b1, exb}) begin n_fail++; $display("FAIL rst_byte%0d: got %h want %h", i, rxb, {1'b1, exb}); end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_header();
    test_overrun();
    test_done_coincident();
    test_saturation();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
